apb_regfile_slave: RTL and testbench

Parametrised APB (AMBA 3/4 subset) completer exposing a bank of NUM_REGS word-wide read/write registers.
- Successor to the fixed 8-bit-address / 32-bit-data APB slave.
- Adds configurable widths, programmable wait states, byte strobes, per-register read-only protection and PSLVERR error signalling.
- Sits behind the APB bridge as a generic control/status register block.

---
 rtl/apb_regfile_slave.sv | 117 +++++++++++
 tb/tb_apb_regfile_slave.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_regfile_slave.sv
// APB completer exposing NUM_REGS word-wide registers with byte strobes,
// programmable wait states, per-register read-only protection and PSLVERR.
module apb_regfile_slave #(
  parameter int                  ADDR_WIDTH  = 8,
  parameter int                  DATA_WIDTH  = 32,
  parameter int                  NUM_REGS    = 32,
  parameter int                  WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0] RO_MASK     = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic                    pwrite,
  input  logic                    psel,
  input  logic                    penable,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pready,
  output logic                    pslverr
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int ALIGN  = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_WIDTH - ALIGN;
  localparam int REG_IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int CNT_W  = 4;

  // Handshake: a transfer completes in the cycle where pready is high while
  // psel and penable are high; pslverr and prdata are only meaningful then.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [DATA_WIDTH-1:0]  regs [NUM_REGS];

  logic [IDX_W-1:0]       idx;
  logic [REG_IW-1:0]      reg_sel;
  logic                   misaligned;
  logic                   idx_oob;
  logic                   ro_hit;
  logic                   err;
  logic                   in_access;
  logic                   cnt_zero;
  logic                   complete;
  logic                   commit;

  assign idx     = paddr[ADDR_WIDTH-1:ALIGN];
  assign reg_sel = idx[REG_IW-1:0];

  generate
    if (ALIGN > 0) begin : g_align
      assign misaligned = |paddr[ALIGN-1:0];
    end else begin : g_no_align
      assign misaligned = 1'b0;
    end
  endgenerate

  assign idx_oob = ({1'b0, idx} >= (IDX_W+1)'(NUM_REGS));
  // The read-only lookup is only trusted for an in-range index.
  assign ro_hit  = !idx_oob && RO_MASK[reg_sel];
  assign err     = misaligned | idx_oob | (pwrite & ro_hit);

  assign in_access = (state == ST_ACCESS);
  assign cnt_zero  = (cnt == '0);
  assign complete  = in_access && psel && cnt_zero;
  assign commit    = complete && pwrite && !err;

  assign pready  = complete && penable;
  assign pslverr = pready && err;
  assign prdata  = (pready && !pwrite && !err) ? regs[reg_sel] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // psel with penable already high here is a protocol violation and is ignored.
          if (psel && !penable) begin
            state <= ST_ACCESS;
            cnt   <= CNT_W'(WAIT_STATES);
          end
        end
        ST_ACCESS: begin
          if (!psel) begin
            state <= ST_IDLE;
          end else if (!cnt_zero) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (commit) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (pstrb[b]) begin
          regs[reg_sel][8*b +: 8] <= pwdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Directed plus random bench for apb_regfile_slave: one writable bank and one
// bank with register 4 read-only, both with two wait states.
module tb_apb_regfile_slave;

  localparam int WS = 2;

  logic        clk;
  logic        rst_n;
  logic [7:0]  paddr;
  logic        pwrite;
  logic        psel_a;
  logic        psel_b;
  logic        penable;
  logic [3:0]  pstrb;
  logic [31:0] pwdata;
  logic [31:0] prdata_a, prdata_b;
  logic        pready_a, pready_b;
  logic        pslverr_a, pslverr_b;

  int total = 0;
  int bad   = 0;

  // {latency[3:0], pslverr, prdata[31:0]}
  logic [36:0] exp_q[$];
  logic [31:0] mdl [2][32];
  bit          sel_now;

  logic        cur_pready;
  logic        cur_pslverr;
  logic [31:0] cur_prdata;

  assign cur_pready  = sel_now ? pready_b  : pready_a;
  assign cur_pslverr = sel_now ? pslverr_b : pslverr_a;
  assign cur_prdata  = sel_now ? prdata_b  : prdata_a;

  apb_regfile_slave #(
    .ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_REGS(32), .WAIT_STATES(WS),
    .RO_MASK(32'h0000_0000)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .paddr(paddr), .pwrite(pwrite), .psel(psel_a),
    .penable(penable), .pstrb(pstrb), .pwdata(pwdata), .prdata(prdata_a),
    .pready(pready_a), .pslverr(pslverr_a)
  );

  apb_regfile_slave #(
    .ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_REGS(32), .WAIT_STATES(WS),
    .RO_MASK(32'h0000_0010)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .paddr(paddr), .pwrite(pwrite), .psel(psel_b),
    .penable(penable), .pstrb(pstrb), .pwdata(pwdata), .prdata(prdata_b),
    .pready(pready_b), .pslverr(pslverr_b)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 32; i++)
        mdl[s][i] = '0;
  endtask

  // Called at posedge+1; drives SETUP immediately so consecutive calls are back-to-back.
  task automatic xfer(input bit sel, input bit wr, input logic [7:0] addr,
                      input logic [31:0] data, input logic [3:0] strb,
                      output logic [31:0] rdata, output logic err);
    logic [5:0]  idx;
    logic        e;
    logic [31:0] edata;
    logic [36:0] expv;
    logic [3:0]  lat;
    idx   = addr[7:2];
    e     = (addr[1:0] != 2'b00) || (idx >= 6'd32) || (wr && sel && idx == 6'd4);
    edata = (!wr && !e) ? mdl[sel][idx[4:0]] : 32'h0;
    if (wr && !e)
      for (int b = 0; b < 4; b++)
        if (strb[b]) mdl[sel][idx[4:0]][8*b +: 8] = data[8*b +: 8];
    exp_q.push_back({4'(WS + 1), e, edata});

    sel_now = sel;
    psel_a  = !sel;
    psel_b  = sel;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = data;
    pstrb   = strb;
    @(posedge clk); #1;
    penable = 1'b1;
    lat = 4'd0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (cur_pready) begin
        lat = 4'(n);
        break;
      end
    end
    rdata = cur_prdata;
    err   = cur_pslverr;
    expv  = exp_q.pop_front();
    check($sformatf("sb_%s_%02h", wr ? "wr" : "rd", addr), {lat, err, rdata}, expv);
    @(posedge clk); #1;
    psel_a  = 1'b0;
    psel_b  = 1'b0;
    penable = 1'b0;
  endtask

  // Write to the writable bank, dropping psel during the second wait cycle.
  task automatic xfer_abort(input logic [7:0] addr, input logic [31:0] data);
    sel_now = 1'b0;
    psel_a  = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = addr;
    pwdata  = data;
    pstrb   = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    check("abort_c1_pready", pready_a, 0);
    @(posedge clk); #1;
    psel_a  = 1'b0;
    penable = 1'b0;
    @(negedge clk);
    check("abort_c2_pready", pready_a, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;

    rst_n   = 1'b0;
    psel_a  = 1'b0;
    psel_b  = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pwdata  = '0;
    pstrb   = '0;
    sel_now = 1'b0;
    clear_model();

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pready",  {pready_a, pready_b},   2'b00);
    check("rst_pslverr", {pslverr_a, pslverr_b}, 2'b00);
    check("rst_prdata",  {prdata_a, prdata_b},   64'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic write/read with wait states
    xfer(0, 1, 8'h40, 32'hDEADBEEF, 4'hF, rd, er);
    check("t1_wr_err", er, 0);
    xfer(0, 0, 8'h40, 32'h0, 4'h0, rd, er);
    check("t1_rd40", rd, 32'hDEADBEEF);
    check("t1_rd40_err", er, 0);
    xfer(0, 0, 8'h10, 32'h0, 4'h0, rd, er);
    check("t1_rd10", rd, 32'h0);

    // Byte strobes and the empty-strobe no-op
    xfer(0, 1, 8'h10, 32'h11223344, 4'b0101, rd, er);
    xfer(0, 0, 8'h10, 32'h0, 4'h0, rd, er);
    check("t2_strb0101", rd, 32'h00220044);
    xfer(0, 1, 8'h10, 32'hAABBCCDD, 4'b1000, rd, er);
    xfer(0, 0, 8'h10, 32'h0, 4'h0, rd, er);
    check("t2_strb1000", rd, 32'hAA220044);
    xfer(0, 1, 8'h40, 32'h0BAD0BAD, 4'b0000, rd, er);
    check("t2_nostrb_err", er, 0);
    xfer(0, 0, 8'h40, 32'h0, 4'h0, rd, er);
    check("t2_nostrb_keep", rd, 32'hDEADBEEF);

    // Out-of-range and misaligned accesses
    xfer(0, 0, 8'h80, 32'h0, 4'h0, rd, er);
    check("t3_rd80_err", er, 1);
    check("t3_rd80_data", rd, 32'h0);
    xfer(0, 1, 8'h41, 32'h01234567, 4'hF, rd, er);
    check("t3_wr41_err", er, 1);
    xfer(0, 0, 8'h40, 32'h0, 4'h0, rd, er);
    check("t3_reg16_keep", rd, 32'hDEADBEEF);

    // Read-only register in the protected bank
    xfer(1, 1, 8'h10, 32'h12345678, 4'hF, rd, er);
    check("t4_ro_wr_err", er, 1);
    xfer(1, 0, 8'h10, 32'h0, 4'h0, rd, er);
    check("t4_ro_rd", rd, 32'h0);
    check("t4_ro_rd_err", er, 0);
    xfer(1, 1, 8'h14, 32'h5A5A5A5A, 4'hF, rd, er);
    check("t4_rw_wr_err", er, 0);
    xfer(1, 0, 8'h14, 32'h0, 4'h0, rd, er);
    check("t4_rw_rd", rd, 32'h5A5A5A5A);

    // Abort in the middle of wait states
    xfer_abort(8'h20, 32'h55555555);
    xfer(0, 0, 8'h20, 32'h0, 4'h0, rd, er);
    check("t5_reg8_keep", rd, 32'h0);

    // psel with penable in IDLE is ignored
    psel_a  = 1'b1;
    penable = 1'b1;
    pwrite  = 1'b1;
    paddr   = 8'h40;
    pwdata  = 32'hFFFFFFFF;
    pstrb   = 4'hF;
    @(negedge clk);
    check("viol_pready", pready_a, 0);
    @(posedge clk); #1;
    psel_a  = 1'b0;
    penable = 1'b0;
    @(negedge clk);
    check("viol_pready2", pready_a, 0);
    @(posedge clk); #1;
    xfer(0, 0, 8'h40, 32'h0, 4'h0, rd, er);
    check("viol_keep", rd, 32'hDEADBEEF);

    // Random traffic on both banks
    for (int k = 0; k < 60; k++) begin
      xfer(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           8'($urandom_range(0, 159)), $urandom, 4'($urandom_range(0, 15)), rd, er);
    end

    // Asynchronous reset while a write is in its pready cycle
    sel_now = 1'b0;
    psel_a  = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 8'h04;
    pwdata  = 32'hCAFEF00D;
    pstrb   = 4'hF;
    @(posedge clk); #1;
    penable = 1'b1;
    repeat (WS + 1) @(negedge clk);
    check("t6_pre_pready", pready_a, 1);
    #1 rst_n = 1'b0;
    #1;
    check("t6_rst_pready",  pready_a,  0);
    check("t6_rst_pslverr", pslverr_a, 0);
    check("t6_rst_prdata",  prdata_a,  32'h0);
    @(posedge clk); #1;
    psel_a  = 1'b0;
    penable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    clear_model();
    @(posedge clk); #1;
    xfer(0, 0, 8'h04, 32'h0, 4'h0, rd, er);
    check("t6_rd04", rd, 32'h0);
    xfer(0, 0, 8'h40, 32'h0, 4'h0, rd, er);
    check("t6_rd40", rd, 32'h0);
    xfer(0, 0, 8'h10, 32'h0, 4'h0, rd, er);
    check("t6_rd10", rd, 32'h0);
    xfer(1, 0, 8'h14, 32'h0, 4'h0, rd, er);
    check("t6_b_rd14", rd, 32'h0);

    check("sb_queue_empty", 64'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
